// File: rtl/imem_loader_if.sv
// Byte-in / word-out bus of the instruction-memory boot loader.
// The master modport is the loader; the slave modport is the UART/RAM side.
interface imem_loader_if #(
    parameter int RAM_SIZE_BIT = 10
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    mem_we;
    logic [RAM_SIZE_BIT-1:0] mem_addr;
    logic [31:0]             mem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Serial boot loader: assembles big-endian words from a UART byte frame into
// instruction RAM and releases the CPU only after a matching XOR checksum.
module imem_loader #(
    parameter int RAM_SIZE_BIT   = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    imem_loader_if.master         bus,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [RAM_SIZE_BIT:0] word_count,
    output logic [2:0]            state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] LEN_MAX = 17'(2 ** RAM_SIZE_BIT);

    // Handshake: a byte is consumed on every rising edge where rx_valid=1 while a
    // session is open; there is no back-pressure. mem_we is a single-cycle strobe.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t                  state, state_next;
    logic [7:0]              len_hi;
    logic [15:0]             len;
    logic [7:0]              csum;
    logic [1:0]              byte_cnt;
    logic [23:0]             word_sh;
    logic [RAM_SIZE_BIT-1:0] addr;
    logic [TW-1:0]           tcnt;

    logic                  in_session;
    logic                  accept_start;
    logic                  take_byte;
    logic                  timeout_hit;
    logic [16:0]           n_full;
    logic                  len_ok;
    logic                  word_last;
    logic [RAM_SIZE_BIT:0] wc_inc;
    logic                  last_word;

    always_comb begin
        in_session   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CHECK);
        accept_start = start && ((state == S_IDLE) || (state == S_ERR));
        take_byte    = in_session && bus.rx_valid;
        timeout_hit  = in_session && !bus.rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
        n_full       = {1'b0, len_hi, bus.rx_data};
        len_ok       = (n_full != 17'd0) && (n_full <= LEN_MAX);
        word_last    = (byte_cnt == 2'd3);
        wc_inc       = word_count + (RAM_SIZE_BIT + 1)'(1);
        last_word    = (17'(wc_inc) == {1'b0, len});
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept_start) state_next = S_LEN_HI;
            S_LEN_HI: if (bus.rx_valid) state_next = S_LEN_LO;
            S_LEN_LO: if (bus.rx_valid) state_next = len_ok ? S_DATA : S_ERR;
            S_DATA:   if (bus.rx_valid && word_last && last_word) state_next = S_CHECK;
            S_CHECK:  if (bus.rx_valid) state_next = (csum == bus.rx_data) ? S_DONE : S_ERR;
            S_DONE:   state_next = S_IDLE;
            S_ERR:    if (accept_start) state_next = S_LEN_HI;
            default:  state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_ERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi        <= '0;
            len           <= '0;
            csum          <= '0;
            byte_cnt      <= '0;
            word_sh       <= '0;
            addr          <= '0;
            tcnt          <= '0;
            word_count    <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (accept_start) begin
                csum       <= '0;
                byte_cnt   <= '0;
                addr       <= '0;
                tcnt       <= '0;
                word_count <= '0;
            end else if (take_byte) begin
                tcnt <= '0;
                csum <= csum ^ bus.rx_data;
                case (state)
                    S_LEN_HI: len_hi <= bus.rx_data;
                    S_LEN_LO: len    <= {len_hi, bus.rx_data};
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sh  <= {word_sh[15:0], bus.rx_data};
                        if (word_last) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= addr;
                            bus.mem_wdata <= {word_sh, bus.rx_data};
                            addr          <= addr + RAM_SIZE_BIT'(1);
                            word_count    <= wc_inc;
                        end
                    end
                    default: ;
                endcase
            end else if (in_session) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // The CPU stays held in ERR so a partial or corrupted image never runs.
    always_comb begin
        busy      = in_session;
        done      = (state == S_DONE);
        error     = (state == S_ERR);
        cpu_hold  = in_session || (state == S_ERR);
        state_dbg = state;
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus hand-written
// timeout and reset-mid-load sequences; RAM writes go through an expected queue.
module tb_imem_loader;
    localparam int RSB = 10;
    localparam int TOC = 16;
    localparam int W   = RSB + 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic           cpu_hold, busy, done, error;
    logic [RSB:0]   word_count;
    logic [2:0]     state_dbg;

    imem_loader_if #(.RAM_SIZE_BIT(RSB)) bus ();

    imem_loader #(.RAM_SIZE_BIT(RSB), .TIMEOUT_CYCLES(TOC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           st;
        logic           rv;
        logic [7:0]     rd;
        logic           we;
        logic [RSB-1:0] ad;
        logic [31:0]    wd;
        logic           busy;
        logic           hold;
        logic           done;
        logic           err;
        logic [RSB:0]   wc;
    } vec_t;

    vec_t       vecs[$];
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rv, input logic [7:0] rd,
                       input logic we, input logic [RSB-1:0] ad, input logic [31:0] wd,
                       input logic b, input logic h, input logic d, input logic e,
                       input logic [RSB:0] wc);
        vec_t v;
        v.st = st; v.rv = rv; v.rd = rd; v.we = we; v.ad = ad; v.wd = wd;
        v.busy = b; v.hold = h; v.done = d; v.err = e; v.wc = wc;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, check #1 after the rising edge, return at the next falling edge.
    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        start = v.st; bus.rx_valid = v.rv; bus.rx_data = v.rd;
        @(posedge clk);
        #1;
        if (v.we) exp_q.push_back({v.ad, v.wd});
        chk($sformatf("vec%0d_ctl", i),
            64'({bus.mem_we, busy, cpu_hold, done, error, word_count}),
            64'({v.we, v.busy, v.hold, v.done, v.err, v.wc}));
        @(negedge clk);
    endtask

    task automatic idle_cycle(input string name, input logic exp_busy, input logic exp_err,
                              input logic [RSB:0] exp_wc);
        start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        @(posedge clk);
        #1;
        chk(name, 64'({busy, error, cpu_hold, word_count}),
            64'({exp_busy, exp_err, 1'b1, exp_wc}));
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        start = 1'b0; bus.rx_valid = 1'b1; bus.rx_data = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Write scoreboard: every observed write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && bus.mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %0h_%0h exp none", bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got %0h_%0h exp %0h", bus.mem_addr, bus.mem_wdata, e);
                end
            end
        end
    end

    initial begin
        // good load
        add(1,0,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h02, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h24, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h17, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h04, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h00, 1,0,32'h24170400, 1,1,0,0,1);
        add(0,1,8'h24, 0,0,32'h0, 1,1,0,0,1);
        add(0,1,8'h08, 0,0,32'h0, 1,1,0,0,1);
        add(0,1,8'h00, 0,0,32'h0, 1,1,0,0,1);
        add(0,1,8'h00, 1,1,32'h24080000, 1,1,0,0,2);
        add(0,1,8'h19, 0,0,32'h0, 0,0,1,0,2);
        add(0,0,8'h00, 0,0,32'h0, 0,0,0,0,2);
        add(0,1,8'h55, 0,0,32'h0, 0,0,0,0,2);
        // bad checksum, with a start pulse ignored mid-DATA
        add(1,0,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h02, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h24, 0,0,32'h0, 1,1,0,0,0);
        add(1,1,8'h17, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h04, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h00, 1,0,32'h24170400, 1,1,0,0,1);
        add(0,1,8'h24, 0,0,32'h0, 1,1,0,0,1);
        add(0,1,8'h08, 0,0,32'h0, 1,1,0,0,1);
        add(0,1,8'h00, 0,0,32'h0, 1,1,0,0,1);
        add(0,1,8'h00, 1,1,32'h24080000, 1,1,0,0,2);
        add(0,1,8'h18, 0,0,32'h0, 0,1,0,1,2);
        add(0,0,8'h00, 0,0,32'h0, 0,1,0,1,2);
        add(0,1,8'h19, 0,0,32'h0, 0,1,0,1,2);
        // start + rx together: byte dropped; then N=0
        add(1,1,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h00, 0,0,32'h0, 0,1,0,1,0);
        // N=0x0401 rejected
        add(1,0,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h04, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h01, 0,0,32'h0, 0,1,0,1,0);
        // N=0x0400 accepted
        add(1,0,8'h00, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h04, 0,0,32'h0, 1,1,0,0,0);
        add(0,1,8'h00, 0,0,32'h0, 1,1,0,0,0);

        reset = 1'b0; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, busy, done, error, word_count, state_dbg}),
            64'(0));
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) apply_vec(i);

        // session opened with N=0x400 times out in DATA
        for (int k = 1; k < TOC; k++) idle_cycle($sformatf("tmo_a_idle%0d", k), 1'b1, 1'b0, '0);
        idle_cycle("tmo_a_expire", 1'b0, 1'b1, '0);

        // timeout after 00 02 24
        apply_vec(0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h24);
        for (int k = 1; k < TOC; k++) idle_cycle($sformatf("tmo_b_idle%0d", k), 1'b1, 1'b0, '0);
        idle_cycle("tmo_b_expire", 1'b0, 1'b1, '0);
        idle_cycle("tmo_b_hold", 1'b0, 1'b1, '0);

        // reset after the 6th byte of the good frame
        for (int i = 0; i <= 6; i++) apply_vec(i);
        #2 reset = 1'b0;
        #1;
        chk("midreset_outputs",
            64'({bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, busy, done, error, word_count, state_dbg}),
            64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 12; i++) apply_vec(i);

        repeat (2) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
